// File: rtl/pipe_text_renderer_pkg.sv
// Shared character codes, opcodes and FSM state encoding for the pipeline text renderer.
package pipe_text_pkg;

    localparam logic [5:0] AN_0 = 6'd0,  AN_1 = 6'd1,  AN_2 = 6'd2,  AN_3 = 6'd3,  AN_4 = 6'd4;
    localparam logic [5:0] AN_5 = 6'd5,  AN_6 = 6'd6,  AN_7 = 6'd7,  AN_8 = 6'd8,  AN_9 = 6'd9;
    localparam logic [5:0] AN_A = 6'd10, AN_B = 6'd11, AN_C = 6'd12, AN_D = 6'd13, AN_E = 6'd14;
    localparam logic [5:0] AN_F = 6'd15, AN_G = 6'd16, AN_H = 6'd17, AN_I = 6'd18, AN_J = 6'd19;
    localparam logic [5:0] AN_K = 6'd20, AN_L = 6'd21, AN_M = 6'd22, AN_N = 6'd23, AN_O = 6'd24;
    localparam logic [5:0] AN_P = 6'd25, AN_Q = 6'd26, AN_R = 6'd27, AN_S = 6'd28, AN_T = 6'd29;
    localparam logic [5:0] AN_U = 6'd30, AN_V = 6'd31, AN_W = 6'd32, AN_X = 6'd33, AN_Y = 6'd34;
    localparam logic [5:0] AN_Z = 6'd35, AN_SP = 6'd36, AN_PT = 6'd37, AN_DS = 6'd38;

    localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_ADDI = 4'd2,  OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_SLT  = 4'd6,  OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9,  OP_SWI  = 4'd10, OP_BEZI = 4'd12, OP_BNZI = 4'd13;
    localparam logic [3:0] OP_BEZR = 4'd14, OP_BNZR = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pipe_text_renderer_lut.sv
// Instruction decode table: one 16-bit instruction and a character index give one display code.
module insn_char_lut
    import pipe_text_pkg::*;
(
    input  logic [15:0] insn,
    input  logic [3:0]  k,
    output logic [5:0]  code
);

    logic [5:0] row [16];
    logic [3:0] op;
    logic [5:0] a, b, c;

    assign op = insn[15:12];
    assign a  = {2'b00, insn[11:8]};
    assign b  = {2'b00, insn[7:4]};
    assign c  = {2'b00, insn[3:0]};

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) row[i] = AN_SP;
        unique case (op)
            OP_NOP:  begin row[0] = AN_N; row[1] = AN_O; row[2] = AN_P; end
            OP_ADD:  begin row[0] = AN_A; row[1] = AN_D; row[2] = AN_D; end
            OP_ADDI: begin row[0] = AN_A; row[1] = AN_D; row[2] = AN_D; row[3] = AN_I; end
            OP_SUB:  begin row[0] = AN_S; row[1] = AN_U; row[2] = AN_B; end
            OP_AND:  begin row[0] = AN_A; row[1] = AN_N; row[2] = AN_D; end
            OP_OR:   begin row[0] = AN_O; row[1] = AN_R; end
            OP_SLT:  begin row[0] = AN_S; row[1] = AN_L; row[2] = AN_T; end
            OP_LW:   begin row[0] = AN_L; row[1] = AN_W; end
            OP_SW:   begin row[0] = AN_S; row[1] = AN_W; end
            OP_SWI:  begin row[0] = AN_S; row[1] = AN_W; row[2] = AN_I; end
            OP_BEZI: begin row[0] = AN_B; row[1] = AN_E; row[2] = AN_Z; row[3] = AN_I; end
            OP_BNZI: begin row[0] = AN_B; row[1] = AN_N; row[2] = AN_Z; row[3] = AN_I; end
            OP_BEZR: begin row[0] = AN_B; row[1] = AN_E; row[2] = AN_Z; row[3] = AN_R; end
            OP_BNZR: begin row[0] = AN_B; row[1] = AN_N; row[2] = AN_Z; row[3] = AN_R; end
            default: ;
        endcase
        unique case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                row[4]  = AN_R; row[5]  = a; row[6]  = AN_PT;
                row[8]  = AN_R; row[9]  = b; row[10] = AN_PT;
                row[12] = AN_R; row[13] = c; row[14] = AN_PT;
            end
            OP_ADDI, OP_SWI, OP_BEZI, OP_BNZI: begin
                row[4] = AN_R;  row[5] = a; row[6]  = AN_PT;
                row[8] = AN_DS; row[9] = b; row[10] = c;
            end
            OP_SW, OP_BEZR, OP_BNZR: begin
                row[4] = AN_R; row[5] = a; row[6]  = AN_PT;
                row[8] = AN_R; row[9] = b; row[10] = AN_PT;
            end
            OP_LW: begin
                row[4] = AN_R; row[5] = b; row[6]  = AN_PT;
                row[8] = AN_R; row[9] = c; row[10] = AN_PT;
            end
            // Undefined opcodes (7, 11) render as a full row of X.
            default: for (int unsigned i = 0; i < 16; i++) row[i] = AN_X;
        endcase
    end

    assign code = row[k];

endmodule

// File: rtl/pipe_text_renderer.sv
// Snapshots every pipeline stage instruction and streams its 16 display characters,
// with pixel coordinates, to the glyph writer; unchanged stages are skipped unless redraw_all.
module pipe_text_renderer
    import pipe_text_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned COL0       = 4,
    parameter int unsigned ROW0       = 300,
    parameter int unsigned COL_PITCH  = 128,
    parameter int unsigned CHAR_W     = 7,
    parameter int unsigned ROW_PITCH  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      redraw_all,
    input  logic [16*NUM_STAGES-1:0]  stage_insn,
    output logic                      char_valid,
    input  logic                      char_ready,
    output logic [5:0]                char_code,
    output logic [9:0]                char_x,
    output logic [9:0]                char_y,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned MAX_STAGES = 8;

    state_e      state_q, state_d;
    logic [3:0]  s_q, s_d, k_q, k_d;
    logic [15:0] snap_q [MAX_STAGES];
    logic [15:0] snap_d [MAX_STAGES];
    logic [15:0] last_q [MAX_STAGES];
    logic [15:0] last_d [MAX_STAGES];
    logic [7:0]  drawn_q, drawn_d;
    logic [5:0]  code_q, code_d;
    logic [9:0]  x_q, x_d, y_q, y_d;

    logic [127:0] insn_pad;
    logic [2:0]   idx;
    logic [3:0]   lut_k, col;
    logic [5:0]   lut_code;
    logic [9:0]   x_pix, y_pix;
    logic         dirty;

    assign insn_pad = 128'(stage_insn);
    assign idx      = s_q[2:0];

    // Outputs are loaded one character ahead: index 0 on SCAN->EMIT, k+1 on each beat.
    assign lut_k = (state_q == ST_EMIT) ? k_q + 4'd1 : '0;
    assign col   = (lut_k < 4'd4) ? lut_k : lut_k - 4'd4;
    assign x_pix = 10'(COL0 + 32'(s_q) * COL_PITCH + 32'(col) * CHAR_W);
    assign y_pix = 10'((lut_k < 4'd4) ? ROW0 : ROW0 + ROW_PITCH);
    assign dirty = redraw_all || !drawn_q[idx] || (snap_q[idx] != last_q[idx]);

    insn_char_lut u_lut (
        .insn (snap_q[idx]),
        .k    (lut_k),
        .code (lut_code)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        snap_d  = snap_q;
        last_d  = last_q;
        drawn_d = drawn_q;
        code_d  = code_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                for (int unsigned i = 0; i < MAX_STAGES; i++)
                    snap_d[i] = (i < NUM_STAGES) ? insn_pad[16*i +: 16] : '0;
                s_d     = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (s_q == 4'(NUM_STAGES)) begin
                    state_d = ST_DONE;
                end else if (dirty) begin
                    k_d     = '0;
                    code_d  = lut_code;
                    x_d     = x_pix;
                    y_d     = y_pix;
                    state_d = ST_EMIT;
                end else begin
                    s_d = s_q + 4'd1;
                end
            end
            ST_EMIT: begin
                if (char_ready) begin
                    if (k_q == 4'd15) begin
                        last_d[idx]  = snap_q[idx];
                        drawn_d[idx] = 1'b1;
                        s_d          = s_q + 4'd1;
                        state_d      = ST_SCAN;
                    end else begin
                        k_d    = k_q + 4'd1;
                        code_d = lut_code;
                        x_d    = x_pix;
                        y_d    = y_pix;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            drawn_q <= '0;
            code_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            for (int unsigned i = 0; i < MAX_STAGES; i++) begin
                snap_q[i] <= '0;
                last_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            drawn_q <= drawn_d;
            code_q  <= code_d;
            x_q     <= x_d;
            y_q     <= y_d;
            for (int unsigned i = 0; i < MAX_STAGES; i++) begin
                snap_q[i] <= snap_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

    assign char_valid = (state_q == ST_EMIT);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign char_code  = code_q;
    assign char_x     = x_q;
    assign char_y     = y_q;

endmodule

// File: doc/pipe_text_renderer.md
Name: pipe_text_renderer

Overview:
Parametrised successor to the single-field pipeline text writer. It snapshots the instruction word of every pipeline stage and decodes each into 16 display characters: a 4-char mnemonic row followed by a 12-char operand row. It streams the characters, with screen coordinates, to the glyph/VRAM writer over a valid/ready handshake. It sits between the CPU pipeline registers and the VRAM line writer, and adds frame-start control, a busy/done status, and dirty-stage skipping.

Parameters:
NUM_STAGES, 5, number of pipeline stages displayed (1..8)
COL0, 4, x pixel of stage 0, char 0
ROW0, 300, y pixel of the mnemonic row
COL_PITCH, 128, x pixels between stage columns
CHAR_W, 7, x pixels per character
ROW_PITCH, 12, y offset of the operand row

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame refresh request
redraw_all  in  1  1: draw every stage; 0: draw only changed stages
stage_insn  in  16*NUM_STAGES  stage s at bits [16s+15:16s], stage 0 = IF
char_valid  out  1  character request valid
char_ready  in  1  glyph writer accepts the character (let_done)
char_code  out  6  character code
char_x  out  10  pixel x
char_y  out  10  pixel y
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; per-stage drawn-valid bits cleared; snapshot and last-drawn registers cleared.
- FSM states: IDLE, LOAD, SCAN, EMIT, DONE.
- IDLE: start=1 -> LOAD. busy=0.
- LOAD (1 cycle): snapshot all of stage_insn; stage index s=0 -> SCAN. busy=1 from LOAD through DONE.
- SCAN (1 cycle per stage examined):
  - If s==NUM_STAGES -> DONE.
  - The stage is dirty if redraw_all, or its drawn-valid bit is 0, or snap[s] != last[s].
  - Dirty: k=0 -> EMIT.
  - Clean: s++ and stay in SCAN.
- EMIT: char_valid=1.
  - code/x/y are registered and stable while valid && !ready.
  - On a beat (valid && ready): if k==15, then last[s] <= snap[s], set drawn-valid[s], s++, -> SCAN; otherwise k++, next character on the following cycle.
  - char_valid stays high across back-to-back beats.
- DONE: frame_done=1 for one cycle -> IDLE.
- start while busy: ignored and not queued.
- stage_insn changes mid-frame: invisible to the frame; only the snapshot is used.
- Coordinates:
  - k<4: x = COL0 + s*COL_PITCH + k*CHAR_W, y = ROW0.
  - k>=4: x = COL0 + s*COL_PITCH + (k-4)*CHAR_W, y = ROW0 + ROW_PITCH.
  - Arithmetic is 10-bit unsigned and truncates on overflow.
- Char codes: 0-9 = digits, 10-35 = A-Z, 36 = SP, 37 = PT ('.'), 38 = DS ('$'). A hex nibble n maps directly to code n.
- Mnemonics by op = insn[15:12]: 0 NOP, 1 ADD, 2 ADDI, 3 SUB, 4 AND, 5 OR, 6 SLT, 8 LW, 9 SW, 10 SWI, 12 BEZI, 13 BNZI, 14 BEZR, 15 BNZR. Mnemonics are left-justified in chars 0-3 and space-padded.
- Operand row (chars 4-15), with a=[11:8], b=[7:4], c=[3:0]; any remainder is SP:
  - R3 (1,3,4,5,6): R a . SP R b . SP R c . SP
  - RI (2,10,12,13): R a . SP $ b c SP...
  - R2 (9,14,15): R a . SP R b . SP...
  - LW (8): R b . SP R c . SP...
  - NOP (0): all SP.
  - op 7 and op 11: all 16 chars X (code 33).
- Reset mid-frame: abort immediately; no frame_done pulse.

Decomposition:
- Package pipe_text_pkg holds:
  - character codes AN_0..AN_9, AN_A..AN_Z, AN_SP, AN_PT, AN_DS
  - opcode constants OP_NOP..OP_BNZR
  - the FSM state enum
- One combinational sub-module, insn_char_lut (insn[15:0], k[3:0] -> code[5:0]), holds the whole mnemonic/operand table so it can be tested alone.
- The parent contains the FSM, counters, snapshot/last registers and coordinate math.

Test Plan:
- Reset, then start, with stage_insn = {16'h0000, 16'h8C5B, 16'h2600, 16'h1106, 16'h6A6C}, redraw_all=1, char_ready=1 -> 80 beats. Stage 0 (SLT) first beats = codes 28,21,29,36 at y=300, x=4,11,18,25. Stage 0 char 4 = 27 at (4,312). frame_done follows the last beat after one SCAN cycle.
- Second start, redraw_all=0, only stage 2 changed to 16'hC062 -> 16 beats, all at x base 260, codes start 11,14,35,18 (BEZI), chars 8-10 = 38,6,2.
- char_ready held low 3 cycles on beat 5 -> char_valid, char_code, char_x, char_y stable for all 4 cycles; total beats unchanged.
- start pulsed while busy, and stage_insn changed mid-frame -> no second frame; emitted characters match the LOAD snapshot.
- rst_n low during beat 7 -> outputs 0 asynchronously; next start with redraw_all=0 redraws all stages (drawn-valid cleared).
- insn_char_lut with op 7 and op 11 -> code 33 for every k in 0..15.
